// File: rtl/rgb_min_stats_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb_min_stats_pkg
// Description : Shared definitions for the RGB minimum stage and its
//               statistics consumer: channel index codes and the output
//               holding-register state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_min_stats_pkg;

   // Channel index codes carried alongside each minimum value.
   localparam logic [1:0] IDX_RED     = 2'd0;
   localparam logic [1:0] IDX_GREEN   = 2'd1;
   localparam logic [1:0] IDX_BLUE    = 2'd2;
   localparam logic [1:0] IDX_INVALID = 2'd3;

   // Output holding register: EMPTY = nothing presented, FULL = result held.
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage
`default_nettype wire

// File: rtl/rgb_min_argmax3.sv
`default_nettype none
// ============================================================================
// Module      : rgb_min_argmax3
// Description : Combinational 3-way count compare. Returns the channel index
//               with the largest count; ties go to the lowest index, so all
//               counts equal (including all zero) yields red.
// Ports       : cnt_red_i, cnt_green_i, cnt_blue_i - counts to compare
//               dominant_o                          - winning channel index
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_min_argmax3
   import rgb_min_stats_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic [CNT_W-1:0] cnt_red_i,
   input  logic [CNT_W-1:0] cnt_green_i,
   input  logic [CNT_W-1:0] cnt_blue_i,
   output logic [1:0]       dominant_o
);

   // Using >= against every higher index gives the lowest-index tie break.
   always_comb begin
      if ((cnt_red_i >= cnt_green_i) && (cnt_red_i >= cnt_blue_i)) begin
         dominant_o = IDX_RED;
      end else if (cnt_green_i >= cnt_blue_i) begin
         dominant_o = IDX_GREEN;
      end else begin
         dominant_o = IDX_BLUE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rgb_min_stats.sv
`default_nettype none
// ============================================================================
// Module      : rgb_min_stats
// Description : Accumulates per-channel hit counts and the value sum of the
//               RGB minimum stream over fixed windows of WINDOW pixels and
//               presents each window result on a valid/ready output with one
//               result of buffering. A result completing while the previous
//               one is still held and not accepted is discarded (drop pulse).
// Ports       : clk, rst_n             - clock, async active-low reset
//               ce, value, index       - sample stream
//               clear                  - synchronous abort of current window
//               out_valid, out_ready   - result handshake
//               cnt_red/green/blue/invalid, sum_value, dominant - result
//               drop                   - completed window discarded
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_min_stats
   import rgb_min_stats_pkg::*;
#(
   parameter int WINDOW = 256,
   parameter int VAL_W  = 10,
   parameter int CNT_W  = 16,
   parameter int SUM_W  = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic [VAL_W-1:0] value,
   input  logic [1:0]       index,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt_red,
   output logic [CNT_W-1:0] cnt_green,
   output logic [CNT_W-1:0] cnt_blue,
   output logic [CNT_W-1:0] cnt_invalid,
   output logic [SUM_W-1:0] sum_value,
   output logic [1:0]       dominant,
   output logic             drop
);

   // Window accumulators
   logic [CNT_W-1:0] cnt_q [4];
   logic [SUM_W-1:0] sum_q;
   logic [CNT_W-1:0] samp_q;

   // Accumulator values including this cycle's sample (the result on completion)
   logic [CNT_W-1:0] cnt_d [4];
   logic [SUM_W-1:0] sum_d;
   logic             accept;
   logic             complete;
   logic             load;
   logic [1:0]       dom_d;

   // Output holding register
   out_state_e       state_q;
   logic             valid_q;
   logic             drop_q;
   logic [CNT_W-1:0] res_cnt_q [4];
   logic [SUM_W-1:0] res_sum_q;
   logic [1:0]       res_dom_q;

   always_comb begin
      accept   = ce & ~clear;
      complete = accept && (samp_q == CNT_W'(WINDOW - 1));
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (accept && (index == 2'(i))) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      sum_d = accept ? (sum_q + SUM_W'(value)) : sum_q;
      // A completion replaces the held result unless it is stuck unaccepted.
      load  = complete && ((state_q == ST_EMPTY) || out_ready);
   end

   rgb_min_argmax3 #(
      .CNT_W      (CNT_W)
   ) u_argmax (
      .cnt_red_i   (cnt_d[IDX_RED]),
      .cnt_green_i (cnt_d[IDX_GREEN]),
      .cnt_blue_i  (cnt_d[IDX_BLUE]),
      .dominant_o  (dom_d)
   );

   // Accumulation runs regardless of output state; completion restarts the
   // window on the same edge so the next sample opens a new window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         sum_q  <= '0;
         samp_q <= '0;
      end else if (clear || complete) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         sum_q  <= '0;
         samp_q <= '0;
      end else if (accept) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         sum_q  <= sum_d;
         samp_q <= samp_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         valid_q   <= 1'b0;
         drop_q    <= 1'b0;
         for (int i = 0; i < 4; i++) res_cnt_q[i] <= '0;
         res_sum_q <= '0;
         res_dom_q <= '0;
      end else begin
         drop_q <= 1'b0;
         if (load) begin
            for (int i = 0; i < 4; i++) res_cnt_q[i] <= cnt_d[i];
            res_sum_q <= sum_d;
            res_dom_q <= dom_d;
         end
         case (state_q)
            ST_EMPTY: begin
               if (complete) begin
                  valid_q <= 1'b1;
                  state_q <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (complete) begin
                  if (!out_ready) drop_q <= 1'b1;
               end else if (out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= ST_EMPTY;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_EMPTY;
            end
         endcase
      end
   end

   assign out_valid   = valid_q;
   assign drop        = drop_q;
   assign cnt_red     = res_cnt_q[IDX_RED];
   assign cnt_green   = res_cnt_q[IDX_GREEN];
   assign cnt_blue    = res_cnt_q[IDX_BLUE];
   assign cnt_invalid = res_cnt_q[IDX_INVALID];
   assign sum_value   = res_sum_q;
   assign dominant    = res_dom_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_min_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_min_stats
// Description : Self-checking bench for rgb_min_stats (WINDOW=4). Directed
//               scenarios followed by randomized traffic, all compared
//               against a window/queue reference model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_min_stats;

   localparam int WINDOW = 4;
   localparam int VAL_W  = 10;
   localparam int CNT_W  = 16;
   localparam int SUM_W  = 26;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ce;
   logic [VAL_W-1:0] value;
   logic [1:0]       index;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] cnt_red;
   logic [CNT_W-1:0] cnt_green;
   logic [CNT_W-1:0] cnt_blue;
   logic [CNT_W-1:0] cnt_invalid;
   logic [SUM_W-1:0] sum_value;
   logic [1:0]       dominant;
   logic             drop;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: samples of the open window, and the presented result.
   int m_win_val[$];
   int m_win_idx[$];
   bit m_valid;
   bit m_drop;
   int m_cnt[4];
   int m_sum;
   int m_dom;

   rgb_min_stats #(
      .WINDOW (WINDOW),
      .VAL_W  (VAL_W),
      .CNT_W  (CNT_W),
      .SUM_W  (SUM_W)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ce          (ce),
      .value       (value),
      .index       (index),
      .clear       (clear),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .cnt_red     (cnt_red),
      .cnt_green   (cnt_green),
      .cnt_blue    (cnt_blue),
      .cnt_invalid (cnt_invalid),
      .sum_value   (sum_value),
      .dominant    (dominant),
      .drop        (drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_win_val.delete();
      m_win_idx.delete();
      m_valid = 1'b0;
      m_drop  = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_sum = 0;
      m_dom = 0;
   endtask

   // One clock edge of the model given the inputs sampled on that edge.
   task automatic model_edge(input bit c, input int v, input int idx, input bit clr, input bit rdy);
      int  r_cnt[4];
      int  r_sum;
      int  r_dom;
      int  mx;
      bit  done;
      done   = 1'b0;
      m_drop = 1'b0;
      if (clr) begin
         m_win_val.delete();
         m_win_idx.delete();
      end else if (c) begin
         m_win_val.push_back(v);
         m_win_idx.push_back(idx);
         if (m_win_val.size() == WINDOW) begin
            for (int i = 0; i < 4; i++) r_cnt[i] = 0;
            r_sum = 0;
            foreach (m_win_val[k]) begin
               r_sum += m_win_val[k];
               r_cnt[m_win_idx[k]]++;
            end
            mx = r_cnt[0];
            if (r_cnt[1] > mx) mx = r_cnt[1];
            if (r_cnt[2] > mx) mx = r_cnt[2];
            r_dom = 2;
            for (int i = 2; i >= 0; i--) if (r_cnt[i] == mx) r_dom = i;
            m_win_val.delete();
            m_win_idx.delete();
            done = 1'b1;
         end
      end
      if (done && (!m_valid || rdy)) begin
         m_valid = 1'b1;
         m_cnt   = r_cnt;
         m_sum   = r_sum;
         m_dom   = r_dom;
      end else if (done) begin
         m_drop = 1'b1;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_outputs();
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("drop", 64'(drop), 64'(m_drop));
      if (m_valid) begin
         check("cnt_red", 64'(cnt_red), 64'(m_cnt[0]));
         check("cnt_green", 64'(cnt_green), 64'(m_cnt[1]));
         check("cnt_blue", 64'(cnt_blue), 64'(m_cnt[2]));
         check("cnt_invalid", 64'(cnt_invalid), 64'(m_cnt[3]));
         check("sum_value", 64'(sum_value), 64'(m_sum));
         check("dominant", 64'(dominant), 64'(m_dom));
      end
   endtask

   // Drive one cycle of inputs, clock it, update the model, compare 1 after edge.
   task automatic step(input bit c, input int v, input int idx, input bit clr, input bit rdy);
      ce        = c;
      value     = VAL_W'(v);
      index     = 2'(idx);
      clear     = clr;
      out_ready = rdy;
      @(posedge clk);
      model_edge(c, v, idx, clr, rdy);
      #1;
      compare_outputs();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_drop"}, 64'(drop), 64'd0);
      check({tag, "_cnts"}, 64'({cnt_red, cnt_green, cnt_blue, cnt_invalid}), 64'd0);
      check({tag, "_sum"}, 64'(sum_value), 64'd0);
      check({tag, "_dom"}, 64'(dominant), 64'd0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero(tag);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int vals_a[4];
      int idx_a[4];
      rst_n     = 1'b0;
      ce        = 1'b0;
      value     = '0;
      index     = '0;
      clear     = 1'b0;
      out_ready = 1'b0;
      model_reset();
      #3;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Window A: idx 0,0,1,2 values 10..40, held un-accepted.
      vals_a = '{10, 20, 30, 40};
      idx_a  = '{0, 0, 1, 2};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, vals_a[i], idx_a[i], 1'b0, 1'b0);
         if (i < 3) check("t1_not_yet_valid", 64'(out_valid), 64'd0);
      end
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_red", 64'(cnt_red), 64'd2);
      check("t1_green", 64'(cnt_green), 64'd1);
      check("t1_blue", 64'(cnt_blue), 64'd1);
      check("t1_invalid", 64'(cnt_invalid), 64'd0);
      check("t1_sum", 64'(sum_value), 64'd100);
      check("t1_dom", 64'(dominant), 64'd0);

      // Second window completes while A is still held: dropped.
      step(1'b1, 1, 1, 1'b0, 1'b0);
      step(1'b1, 2, 2, 1'b0, 1'b0);
      step(1'b1, 3, 2, 1'b0, 1'b0);
      step(1'b1, 4, 1, 1'b0, 1'b0);
      check("t3_drop", 64'(drop), 64'd1);
      check("t3_held_red", 64'(cnt_red), 64'd2);
      check("t3_held_sum", 64'(sum_value), 64'd100);
      step(1'b0, 0, 0, 1'b0, 1'b1);
      check("t3_drop_one_cycle", 64'(drop), 64'd0);
      check("t3_valid_falls", 64'(out_valid), 64'd0);

      // Green/blue tie resolves to green.
      step(1'b1, 7, 1, 1'b0, 1'b0);
      step(1'b1, 8, 2, 1'b0, 1'b0);
      step(1'b1, 9, 2, 1'b0, 1'b0);
      step(1'b1, 6, 1, 1'b0, 1'b0);
      check("t2_dom_tie", 64'(dominant), 64'd1);
      check("t2_sum", 64'(sum_value), 64'd30);

      // All-invalid window, accepted on the same edge as its completion.
      step(1'b1, 100, 3, 1'b0, 1'b0);
      step(1'b1, 200, 3, 1'b0, 1'b0);
      step(1'b1, 300, 3, 1'b0, 1'b0);
      step(1'b1, 1023, 3, 1'b0, 1'b1);
      check("t4_valid_stays", 64'(out_valid), 64'd1);
      check("t4_drop", 64'(drop), 64'd0);
      check("t2_invalid", 64'(cnt_invalid), 64'd4);
      check("t2_dom_zero", 64'(dominant), 64'd0);
      check("t4_sum", 64'(sum_value), 64'd1623);
      step(1'b0, 0, 0, 1'b0, 1'b1);

      // Clear discards the partial window and its own sample.
      step(1'b1, 50, 0, 1'b0, 1'b0);
      step(1'b1, 60, 1, 1'b0, 1'b0);
      step(1'b1, 70, 2, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 5, i % 3, 1'b0, 1'b0);
      check("t5_sum", 64'(sum_value), 64'd20);
      check("t5_total", 64'(cnt_red + cnt_green + cnt_blue + cnt_invalid), 64'd4);
      step(1'b0, 0, 0, 1'b0, 1'b1);

      // Reset mid-window, then while FULL.
      step(1'b1, 11, 0, 1'b0, 1'b0);
      step(1'b1, 12, 1, 1'b0, 1'b0);
      async_reset("t6_midwin");
      for (int i = 0; i < 4; i++) step(1'b1, 13 + i, 2, 1'b0, 1'b0);
      check("t6_full_before", 64'(out_valid), 64'd1);
      async_reset("t6_full");
      for (int i = 0; i < 3; i++) step(1'b1, 20, 1, 1'b0, 1'b0);
      check("t6_needs_full_window", 64'(out_valid), 64'd0);
      step(1'b1, 20, 1, 1'b0, 1'b0);
      check("t6_new_window", 64'(out_valid), 64'd1);
      check("t6_sum", 64'(sum_value), 64'd80);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 2) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
